// File: rtl/risc_run_ctrl.sv
// risc_run_ctrl: run-control and cycle-budget monitor for the Risc_16_bit core.
// It gates the core through a registered clock enable and counts enabled
// cycles against MAX_CYCLES. It declares halt when the PC stays unchanged for
// STALL_LIMIT enabled cycles, supports free-run and single-step modes, and
// reports why the run ended through done_code.
//
// Optional feature: define RUN_CTRL_BREAKPOINT_EN to add the bp_valid/bp_addr
// inputs and the breakpoint termination (done_code 2'b11). Without the macro
// those ports do not exist and code 2'b11 is never produced.

module risc_run_ctrl #(
    parameter int PC_W        = 16,
    parameter int CNT_W       = 32,
    parameter int MAX_CYCLES  = 160,
    parameter int STALL_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             abort,
    input  logic [PC_W-1:0]  pc_in,
`ifdef RUN_CTRL_BREAKPOINT_EN
    input  logic             bp_valid,
    input  logic [PC_W-1:0]  bp_addr,
`endif
    output logic             core_en,
    output logic             done,
    output logic [1:0]       done_code,
    output logic [CNT_W-1:0] cycle_count
);

    // FSM encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RUN       = 3'd1;
    localparam logic [2:0] ST_STEP_WAIT = 3'd2;
    localparam logic [2:0] ST_STEP_EXEC = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    // Completion codes
    localparam logic [1:0] CODE_ABORT   = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_HALT    = 2'b10;
    localparam logic [1:0] CODE_BREAK   = 2'b11;

    // The stall counter only has to reach STALL_LIMIT; the run ends there,
    // so the counter never needs to wrap.
    localparam int STALL_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);

    logic [2:0]         r_state;
    logic               r_core_en;
    logic               r_done;
    logic [1:0]         r_done_code;
    logic [CNT_W-1:0]   r_cycle_count;
    logic [STALL_W-1:0] r_stall;
    logic [PC_W-1:0]    r_pc_prev;
    logic               r_pc_valid;
    logic               r_step_prev;

    logic               w_en_cycle;
    logic               w_active;
    logic               w_start_ok;
    logic               w_step_rise;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_pc_same;
    logic [STALL_W-1:0] w_stall_nxt;
    logic               w_halt;
    logic               w_timeout;
    logic               w_abort;
    logic               w_bp;
    logic               w_terminate;
    logic [1:0]         w_term_code;

    // Decode this cycle's events; every termination test uses the values the
    // counters will hold after the current edge.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        w_en_cycle  = r_core_en;
        w_active    = (r_state == ST_RUN) || (r_state == ST_STEP_WAIT) ||
                      (r_state == ST_STEP_EXEC);
        w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_step_rise = step_req && !r_step_prev;
        w_cnt_inc   = r_cycle_count + CNT_W'(1);
        w_pc_same   = r_pc_valid && (pc_in == r_pc_prev);
        w_stall_nxt = '0;
        if (w_pc_same && (STALL_LIMIT != 0)) begin
            w_stall_nxt = r_stall + STALL_W'(1);
        end
        w_halt      = w_en_cycle && (STALL_LIMIT != 0) &&
                      (w_stall_nxt == STALL_W'(STALL_LIMIT));
        w_timeout   = w_en_cycle && (w_cnt_inc == CNT_W'(MAX_CYCLES));
        w_abort     = w_active && abort;
`ifdef RUN_CTRL_BREAKPOINT_EN
        w_bp        = w_en_cycle && bp_valid && (pc_in == bp_addr);
`else
        w_bp        = 1'b0;
`endif
        w_terminate = w_bp || w_halt || w_timeout || w_abort;

        // Simultaneous causes resolve as breakpoint > halt > timeout > abort.
        w_term_code = CODE_ABORT;
        if (w_bp) begin
            w_term_code = CODE_BREAK;
        end else if (w_halt) begin
            w_term_code = CODE_HALT;
        end else if (w_timeout) begin
            w_term_code = CODE_TIMEOUT;
        end
    end

    // Remember the previous step_req sample for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of the order of statements.
        if (!rst_n) begin
            r_step_prev <= 1'b0;
        end else begin
            r_step_prev <= step_req;
        end
    end

    // Account for enabled cycles: count, track the PC and the stall length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_count <= '0;
            r_stall       <= '0;
            r_pc_prev     <= '0;
            r_pc_valid    <= 1'b0;
        end else if (w_start_ok) begin
            r_cycle_count <= '0;
            r_stall       <= '0;
            r_pc_valid    <= 1'b0;
        end else if (w_en_cycle) begin
            r_cycle_count <= w_cnt_inc;
            r_stall       <= w_stall_nxt;
            r_pc_prev     <= pc_in;
            r_pc_valid    <= 1'b1;
        end
    end

    // Run-control FSM; it also drives the registered enable and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_core_en   <= 1'b0;
            r_done      <= 1'b0;
            r_done_code <= CODE_ABORT;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_done      <= 1'b0;
                        r_done_code <= CODE_ABORT;
                        // The enable rises on this edge for a free run, so
                        // the first enabled cycle follows the start sample.
                        r_core_en   <= !step_mode;
                        r_state     <= step_mode ? ST_STEP_WAIT : ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (w_terminate) begin
                        r_state     <= ST_DONE;
                        r_core_en   <= 1'b0;
                        r_done      <= 1'b1;
                        r_done_code <= w_term_code;
                    end
                end

                ST_STEP_WAIT: begin
                    // Only abort can end a run while the core is gated off.
                    if (w_terminate) begin
                        r_state     <= ST_DONE;
                        r_core_en   <= 1'b0;
                        r_done      <= 1'b1;
                        r_done_code <= w_term_code;
                    end else if (w_step_rise) begin
                        r_state     <= ST_STEP_EXEC;
                        r_core_en   <= 1'b1;
                    end
                end

                ST_STEP_EXEC: begin
                    r_core_en <= 1'b0;
                    if (w_terminate) begin
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_done_code <= w_term_code;
                    end else begin
                        r_state     <= ST_STEP_WAIT;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_core_en <= 1'b0;
                end
            endcase
        end
    end

    assign core_en     = r_core_en;
    assign done        = r_done;
    assign done_code   = r_done_code;
    assign cycle_count = r_cycle_count;

endmodule
